// File: rtl/mcycle_arbiter.sv
// Round-robin arbiter sharing one MCycle mul/div unit between two ports.
// Optional watchdog abort: define MCYCLE_ARB_TIMEOUT_EN.
module mcycle_arbiter #(
    parameter int WIDTH          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Req0,
    input  logic             Req1,
    input  logic [1:0]       Op0,
    input  logic [1:0]       Op1,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B0,
    input  logic [WIDTH-1:0] B1,
    output logic [1:0]       Grant,
    output logic             Done0,
    output logic             Done1,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Err,
    output logic             MC_Start,
    output logic [1:0]       MC_Op,
    output logic [WIDTH-1:0] MC_A,
    output logic [WIDTH-1:0] MC_B,
    input  logic [WIDTH-1:0] MC_Result1,
    input  logic [WIDTH-1:0] MC_Result2,
    input  logic             MC_Busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state, state_n;
    logic             last, last_n;
    logic             pick1;
    logic [1:0]       grant_n, op_n;
    logic             done0_n, done1_n, start_n;
    logic [WIDTH-1:0] a_n, b_n, r1_n, r2_n;

    // Port 1 wins when alone, or when both ask and port 0 was served last
    assign pick1 = Req1 & (~Req0 | ~last);

`ifdef MCYCLE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt, cnt_n;
    logic          err_q, err_n;
    logic          tmo, abort;
    assign tmo = (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign Err = err_q;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES > 0);
    assign Err = 1'b0;
`endif

    // Next-state and next-output computation; all outputs are registered
    always_comb begin
        state_n = state;
        last_n  = last;
        grant_n = Grant;
        done0_n = 1'b0;
        done1_n = 1'b0;
        start_n = MC_Start;
        op_n    = MC_Op;
        a_n     = MC_A;
        b_n     = MC_B;
        r1_n    = Result1;
        r2_n    = Result2;
`ifdef MCYCLE_ARB_TIMEOUT_EN
        cnt_n   = cnt;
        err_n   = 1'b0;
        abort   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (Req0 || Req1) begin
                    state_n = ISSUE;
                    start_n = 1'b1;
                    grant_n = pick1 ? 2'b10 : 2'b01;
                    op_n    = pick1 ? Op1 : Op0;
                    a_n     = pick1 ? A1 : A0;
                    b_n     = pick1 ? B1 : B0;
`ifdef MCYCLE_ARB_TIMEOUT_EN
                    cnt_n   = '0;
`endif
                end
            end
            ISSUE: begin
                if (MC_Busy) begin
                    start_n = 1'b0;
                    state_n = WAIT;
                end
`ifdef MCYCLE_ARB_TIMEOUT_EN
                else if (tmo) begin
                    abort = 1'b1;
                end
                cnt_n = cnt + CW'(1);
`endif
            end
            WAIT: begin
                if (!MC_Busy) begin
                    r1_n    = MC_Result1;
                    r2_n    = MC_Result2;
                    done0_n = Grant[0];
                    done1_n = Grant[1];
                    state_n = DONE;
                end
`ifdef MCYCLE_ARB_TIMEOUT_EN
                else if (tmo) begin
                    abort = 1'b1;
                end
                cnt_n = cnt + CW'(1);
`endif
            end
            DONE: begin
                grant_n = 2'b00;
                last_n  = Grant[1];
                state_n = IDLE;
            end
        endcase
`ifdef MCYCLE_ARB_TIMEOUT_EN
        if (abort) begin
            start_n = 1'b0;
            r1_n    = '0;
            r2_n    = '0;
            err_n   = 1'b1;
            done0_n = Grant[0];
            done1_n = Grant[1];
            state_n = DONE;
        end
`endif
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state    <= IDLE;
            last     <= 1'b1;
            Grant    <= 2'b00;
            Done0    <= 1'b0;
            Done1    <= 1'b0;
            MC_Start <= 1'b0;
            MC_Op    <= 2'b00;
            MC_A     <= '0;
            MC_B     <= '0;
            Result1  <= '0;
            Result2  <= '0;
`ifdef MCYCLE_ARB_TIMEOUT_EN
            cnt      <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            last     <= last_n;
            Grant    <= grant_n;
            Done0    <= done0_n;
            Done1    <= done1_n;
            MC_Start <= start_n;
            MC_Op    <= op_n;
            MC_A     <= a_n;
            MC_B     <= b_n;
            Result1  <= r1_n;
            Result2  <= r2_n;
`ifdef MCYCLE_ARB_TIMEOUT_EN
            cnt      <= cnt_n;
            err_q    <= err_n;
`endif
        end
    end

endmodule

// File: tb/tb_mcycle_arbiter.sv
// Testbench for mcycle_arbiter with a behavioural MCycle stub.
// Honours MCYCLE_ARB_TIMEOUT_EN for the watchdog scenario.
module tb_mcycle_arbiter;

    localparam int W   = 4;
    localparam int TMO = 8;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         Req0, Req1;
    logic [1:0]   Op0, Op1;
    logic [W-1:0] A0, A1, B0, B1;
    logic [1:0]   Grant;
    logic         Done0, Done1;
    logic [W-1:0] Result1, Result2;
    logic         Err;
    logic         MC_Start;
    logic [1:0]   MC_Op;
    logic [W-1:0] MC_A, MC_B;
    logic [W-1:0] MC_Result1, MC_Result2;
    logic         MC_Busy;

    mcycle_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .RESET(RESET),
        .Req0(Req0), .Req1(Req1),
        .Op0(Op0), .Op1(Op1),
        .A0(A0), .A1(A1), .B0(B0), .B1(B1),
        .Grant(Grant), .Done0(Done0), .Done1(Done1),
        .Result1(Result1), .Result2(Result2), .Err(Err),
        .MC_Start(MC_Start), .MC_Op(MC_Op),
        .MC_A(MC_A), .MC_B(MC_B),
        .MC_Result1(MC_Result1), .MC_Result2(MC_Result2),
        .MC_Busy(MC_Busy)
    );

    always #5 CLK = ~CLK;

    // Reference arithmetic: returns {high/remainder, low/quotient}
    function automatic logic [7:0] ref_op(logic [1:0] op, logic [3:0] a, logic [3:0] b);
        int sa, sb, ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = int'(a);
        ub = int'(b);
        case (op)
            2'b00: return 8'(sa * sb);
            2'b01: return 8'(ua * ub);
            2'b10: return (sb == 0) ? 8'h00 : {4'(sa % sb), 4'(sa / sb)};
            default: return (ub == 0) ? 8'h00 : {4'(ua % ub), 4'(ua / ub)};
        endcase
    endfunction

    // MCycle stub: Busy high for 5 cycles after Start, or forever if hold_busy
    logic hold_busy = 1'b0;
    int   mc_left;
    always @(posedge CLK) begin
        if (!RESET) begin
            MC_Busy    <= 1'b0;
            mc_left    <= 0;
            MC_Result1 <= '0;
            MC_Result2 <= '0;
        end else if (!MC_Busy && MC_Start) begin
            MC_Busy <= 1'b1;
            mc_left <= 5;
            {MC_Result2, MC_Result1} <= ref_op(MC_Op, MC_A, MC_B);
        end else if (MC_Busy && !hold_busy) begin
            if (mc_left == 1) MC_Busy <= 1'b0;
            mc_left <= mc_left - 1;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Request-side model state
    logic       last;
    logic       pend   [2];
    logic [1:0] p_op   [2];
    logic [3:0] p_a    [2];
    logic [3:0] p_b    [2];
    logic [3:0] r1_of  [2];
    logic [3:0] r2_of  [2];
    int         seq[$];

    function automatic logic [1:0] oh(int p);
        return (p == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic set_port(int p, logic [1:0] op, logic [3:0] a, logic [3:0] b);
        p_op[p] = op;
        p_a[p]  = a;
        p_b[p]  = b;
        if (p == 0) begin
            Op0 = op; A0 = a; B0 = b;
        end else begin
            Op1 = op; A1 = a; B1 = b;
        end
    endtask

    task automatic set_req(int p, logic v);
        pend[p] = v;
        if (p == 0) Req0 = v;
        else Req1 = v;
    endtask

    task automatic rnd_port(int p);
        logic [1:0] op;
        logic [3:0] a, b;
        op = 2'($urandom_range(0, 3));
        a  = 4'($urandom);
        b  = 4'($urandom);
        if (op[1] && b == 4'h0) b = 4'h1;
        if (op == 2'b10 && a == 4'h8 && b == 4'hF) b = 4'h1;
        set_port(p, op, a, b);
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        set_req(0, 1'b0);
        set_req(1, 1'b0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        last  = 1'b1;
    endtask

    // Serve pending requests, checking order, latching and results
    task automatic run(input int n_ops, input bit hold);
        int         done_cnt;
        int         guard;
        int         ep;
        bit         granted;
        logic [1:0] c_op;
        logic [3:0] c_a, c_b, e1, e2;
        done_cnt = 0;
        c_op = 2'b00; c_a = 4'h0; c_b = 4'h0;
        while (done_cnt < n_ops && (pend[0] || pend[1])) begin
            if (pend[0] && pend[1]) ep = last ? 0 : 1;
            else ep = pend[1] ? 1 : 0;
            guard   = 0;
            granted = 1'b0;
            while (!(Done0 || Done1) && guard < 60) begin
                @(negedge CLK);
                guard++;
                if (!granted && Grant != 2'b00) begin
                    granted = 1'b1;
                    chk("grant", 32'(Grant), 32'(oh(ep)));
                    chk("mc_op", 32'(MC_Op), 32'(p_op[ep]));
                    chk("mc_a", 32'(MC_A), 32'(p_a[ep]));
                    chk("mc_b", 32'(MC_B), 32'(p_b[ep]));
                    c_op = p_op[ep];
                    c_a  = p_a[ep];
                    c_b  = p_b[ep];
                    rnd_port(ep);
                end
            end
            if (!(Done0 || Done1)) begin
                chk("done_timeout", 32'd0, 32'd1);
                set_req(0, 1'b0);
                set_req(1, 1'b0);
                return;
            end
            {e2, e1} = ref_op(c_op, c_a, c_b);
            chk("done_port", 32'({Done1, Done0}), 32'(oh(ep)));
            chk("result1", 32'(Result1), 32'(e1));
            chk("result2", 32'(Result2), 32'(e2));
            chk("err", 32'(Err), 32'd0);
            r1_of[ep] = Result1;
            r2_of[ep] = Result2;
            seq.push_back(Done1 ? 1 : 0);
            last = ep[0];
            done_cnt++;
            if (hold && done_cnt == n_ops) begin
                set_req(0, 1'b0);
                set_req(1, 1'b0);
            end else if (!hold) begin
                set_req(ep, 1'b0);
            end
            @(negedge CLK);
            chk("done_pulse", 32'({Done1, Done0}), 32'd0);
            chk("grant_idle", 32'(Grant), 32'd0);
        end
    endtask

    initial begin
        int  guard;
        int  cyc;
        bit  seen;
        bit  w0, w1;
        RESET = 1'b0;
        Req0 = 1'b0; Req1 = 1'b0;
        Op0 = 2'b00; Op1 = 2'b00;
        A0 = '0; A1 = '0; B0 = '0; B1 = '0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        last = 1'b1;

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_grant", 32'(Grant), 32'd0);
        chk("rst_done", 32'({Done1, Done0, Err}), 32'd0);
        chk("rst_start", 32'(MC_Start), 32'd0);
        chk("rst_res", 32'({Result2, Result1}), 32'd0);
        chk("rst_mc", 32'({MC_Op, MC_A, MC_B}), 32'd0);
        RESET = 1'b1;
        last  = 1'b1;

        // smul -1 * -1
        set_port(0, 2'b00, 4'hF, 4'hF);
        set_req(0, 1'b1);
        run(1, 1'b0);
        chk("smul_r1", 32'(r1_of[0]), 32'h1);
        chk("smul_r2", 32'(r2_of[0]), 32'h0);

        // Simultaneous requests after reset: port 0 first
        do_reset();
        seq.delete();
        set_port(0, 2'b01, 4'h2, 4'h6);
        set_port(1, 2'b11, 4'h8, 4'h4);
        set_req(0, 1'b1);
        set_req(1, 1'b1);
        run(2, 1'b0);
        chk("both_n", 32'(seq.size()), 32'd2);
        if (seq.size() == 2) begin
            chk("both_first", 32'(seq[0]), 32'd0);
            chk("both_second", 32'(seq[1]), 32'd1);
        end
        chk("umul_r1", 32'(r1_of[0]), 32'hC);
        chk("udiv_r1", 32'(r1_of[1]), 32'h2);
        chk("udiv_r2", 32'(r2_of[1]), 32'h0);

        // Both held high for four operations: strict alternation
        seq.delete();
        rnd_port(0);
        rnd_port(1);
        set_req(0, 1'b1);
        set_req(1, 1'b1);
        run(4, 1'b1);
        chk("alt_n", 32'(seq.size()), 32'd4);
        for (int i = 0; i < seq.size(); i++)
            chk("alt_port", 32'(seq[i]), 32'(i % 2));

        // Reset during WAIT aborts silently
        set_port(0, 2'b01, 4'h3, 4'h3);
        set_req(0, 1'b1);
        guard = 0;
        while (!(Grant != 2'b00 && !MC_Start && MC_Busy) && guard < 30) begin
            @(negedge CLK);
            guard++;
        end
        chk("reach_wait", 32'(guard < 30), 32'd1);
        RESET = 1'b0;
        set_req(0, 1'b0);
        @(negedge CLK);
        chk("mid_rst_grant", 32'(Grant), 32'd0);
        chk("mid_rst_start", 32'(MC_Start), 32'd0);
        chk("mid_rst_done", 32'({Done1, Done0}), 32'd0);
        RESET = 1'b1;
        last  = 1'b1;
        seen  = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            if (Done0 || Done1) seen = 1'b1;
        end
        chk("mid_rst_nodone", 32'(seen), 32'd0);
        set_port(0, 2'b10, 4'hC, 4'h3);
        set_req(0, 1'b1);
        run(1, 1'b0);
        chk("sdiv_r1", 32'(r1_of[0]), 32'hF);
        chk("sdiv_r2", 32'(r2_of[0]), 32'hF);

        // Randomized traffic
        for (int k = 0; k < 25; k++) begin
            w0 = 1'($urandom);
            w1 = 1'($urandom);
            if (!w0 && !w1) w0 = 1'b1;
            if (w0) begin rnd_port(0); set_req(0, 1'b1); end
            if (w1) begin rnd_port(1); set_req(1, 1'b1); end
            run(2, 1'b0);
        end

        // MCycle stuck busy
        hold_busy = 1'b1;
        set_port(0, 2'b01, 4'h5, 4'h5);
        set_req(0, 1'b1);
        guard = 0;
        while (!MC_Start && guard < 10) begin
            @(negedge CLK);
            guard++;
        end
        chk("stuck_start", 32'(MC_Start), 32'd1);
`ifdef MCYCLE_ARB_TIMEOUT_EN
        cyc = 0;
        while (!(Done0 || Done1) && cyc < 40) begin
            @(negedge CLK);
            cyc++;
        end
        chk("tmo_cycles", 32'(cyc), 32'd8);
        chk("tmo_done", 32'({Done1, Done0}), 32'b01);
        chk("tmo_err", 32'(Err), 32'd1);
        chk("tmo_res", 32'({Result2, Result1}), 32'd0);
        chk("tmo_start", 32'(MC_Start), 32'd0);
        set_req(0, 1'b0);
        @(negedge CLK);
        chk("tmo_err_pulse", 32'(Err), 32'd0);
`else
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 40) begin
            @(negedge CLK);
            if (Done0 || Done1 || Err) seen = 1'b1;
            cyc++;
        end
        chk("stuck_nodone", 32'(seen), 32'd0);
        chk("stuck_grant", 32'(Grant), 32'b01);
        chk("stuck_start_lo", 32'(MC_Start), 32'd0);
`endif
        hold_busy = 1'b0;
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
